// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Counter wide enough to hold the values 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational N-bit subtractor (a - b) with a parallel-prefix carry network.
module cla_subtractor #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N-1:0] grp_g;
  logic [N-1:0] grp_p;
  logic [N-1:0] nxt_g;
  logic [N-1:0] nxt_p;
  logic [N:0]   carry;

  // a + ~b + 1: group generate/propagate built in log2(N) prefix stages.
  always_comb begin
    gen   = a & ~b;
    prop  = a ^ ~b;
    grp_g = gen;
    grp_p = prop;
    nxt_g = gen;
    nxt_p = prop;
    for (int d = 1; d < int'(N); d = d * 2) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = d; i < int'(N); i++) begin
        nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
        nxt_p[i] = grp_p[i] & grp_p[i-d];
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    carry  = {grp_g | grp_p, 1'b1};
    diff   = prop ^ carry[N-1:0];
    borrow = ~carry[N];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN to add the in_signed port for two's-complement division.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               div_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dvd_neg, dvs_neg;
`endif

  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic               unused_diff_msb;

  assign partial         = {rem_q, quo_q[WIDTH-1]};
  assign unused_diff_msb = diff[WIDTH];

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (partial),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Next-state and datapath; the dividend shifts out of quo_q as quotient bits shift in.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    div_zero    = (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dvd_neg     = in_signed & dividend[WIDTH-1];
    dvs_neg     = in_signed & divisor[WIDTH-1];
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          zero_d  = div_zero;
          cnt_d   = '0;
          rem_d   = '0;
          state_d = div_zero ? S_FIX : S_BUSY;
`ifdef SEQ_DIVIDER_SIGNED_EN
          // Divide-by-zero keeps the raw dividend so it can be returned unchanged.
          quo_d     = (dvd_neg && !div_zero) ? (~dividend + WIDTH'(1)) : dividend;
          dvs_d     = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
`else
          quo_d = dividend;
          dvs_d = divisor;
`endif
        end
      end
      S_BUSY: begin
        rem_d = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        dbz_d   = zero_q;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          quotient_d  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
`else
          quotient_d  = quo_q;
          remainder_d = rem_q;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (WIDTH=8): arithmetic reference model plus directed vectors.
module tb_seq_divider;

  localparam int unsigned W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_signed_r = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       in_ready, out_valid, div_by_zero;
  logic [7:0] quotient, remainder;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .in_signed   (in_signed_r),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct packed {
    logic       dbz;
    logic [7:0] q;
    logic [7:0] r;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;
  int   n_in = 0;
  int   n_out = 0;
  bit   after_rst = 1'b0;
  bit   exp_ready = 1'b0;
  bit   seen_valid = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Division semantics straight from the arithmetic definition.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    res_t m;
    int   sa, sb, qi, ri;
    if (b == 8'd0) begin
      m.dbz = 1'b1; m.q = 8'hFF; m.r = a;
    end else if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      qi = sa / sb; ri = sa % sb;
      m.dbz = 1'b0; m.q = qi[7:0]; m.r = ri[7:0];
    end else begin
      m.dbz = 1'b0; m.q = a / b; m.r = a % b;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare on the falling edge; bookkeeping looks ahead to the next rising edge.
  always @(negedge clk) begin
    if (after_rst) begin
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
    end
    check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
    if (exp_ready) check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_valid_unexpected: got 1 expected 0 (t=%0t)", $time);
      end else begin
        check("quotient", 32'(quotient), 32'(exp_q[0].q));
        check("remainder", 32'(remainder), 32'(exp_q[0].r));
        check("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
        if (!seen_valid) begin
          // Latency counts the accepting edge as the first edge.
          check("latency", 32'(ecnt - acc_q[0] + 1), exp_q[0].dbz ? 32'd2 : 32'(W + 2));
          seen_valid = 1'b1;
        end
      end
    end
    exp_ready = 1'b0;
    if (rst) begin
      exp_q.delete(); acc_q.delete();
      seen_valid = 1'b0; after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front()); void'(acc_q.pop_front());
        n_out++; seen_valid = 1'b0; exp_ready = 1'b1;
      end
      if (in_valid && in_ready) begin
        check("accept_only_when_idle", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(model(dividend, divisor, in_signed_r & SIG_EN));
        acc_q.push_back(ecnt + 1);
        n_in++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    dividend = a; divisor = b; in_signed_r = s; in_valid = 1'b1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold, input logic [7:0] eq, input logic [7:0] er,
                         input logic ed, input string name);
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got out_valid 0 expected 1", name);
    end else begin
      check({name, "_q"}, 32'(quotient), 32'(eq));
      check({name, "_r"}, 32'(remainder), 32'(er));
      check({name, "_dbz"}, 32'(div_by_zero), 32'(ed));
    end
    out_ready = 1'b0;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_in_ready_next"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n, in0, out0;
    repeat (3) tick();
    rst = 1'b0;

    send(8'd100, 8'd7, 1'b0);   collect(0, 8'd14, 8'd2, 1'b0, "100_7");
    send(8'd55, 8'd0, 1'b0);    collect(0, 8'hFF, 8'd55, 1'b1, "55_0");
    send(8'd200, 8'd3, 1'b0);   collect(5, 8'd66, 8'd2, 1'b0, "200_3_hold");
    send(8'd255, 8'd1, 1'b0);   collect(1, 8'd255, 8'd0, 1'b0, "255_1");
    send(8'd5, 8'd255, 1'b0);   collect(0, 8'd0, 8'd5, 1'b0, "5_255");
    send(8'd0, 8'd9, 1'b0);     collect(0, 8'd0, 8'd0, 1'b0, "0_9");
    send(8'd255, 8'd255, 1'b0); collect(0, 8'd1, 8'd0, 1'b0, "255_255");

    // Reset during the 4th BUSY cycle abandons the operation.
    send(8'd250, 8'd7, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (12) tick();
    send(8'd9, 8'd4, 1'b0);     collect(0, 8'd2, 8'd1, 1'b0, "9_4");

`ifdef SEQ_DIVIDER_SIGNED_EN
    send(8'hF9, 8'd2, 1'b1);    collect(0, 8'hFD, 8'hFF, 1'b0, "s_m7_2");
    send(8'd7, 8'hFE, 1'b1);    collect(0, 8'hFD, 8'h01, 1'b0, "s_7_m2");
    send(8'h80, 8'hFF, 1'b1);   collect(0, 8'h80, 8'h00, 1'b0, "s_m128_m1");
    send(8'hFB, 8'h00, 1'b1);   collect(0, 8'hFF, 8'hFB, 1'b1, "s_m5_0");
`endif

    // Back-to-back with in_valid held high; results checked by the compare process.
    in0 = n_in; out0 = n_out;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dividend = 8'($urandom);
      divisor = (i == 5) ? 8'd0 : 8'($urandom_range(1, 255));
      in_signed_r = SIG_EN & 1'($urandom_range(0, 1));
      n = 0;
      while (!in_ready && n < 200) begin tick(); n++; end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    out_ready = 1'b0;
    repeat (2) tick();
    check("b2b_accepts", 32'(n_in - in0), 32'd16);
    check("b2b_results", 32'(n_out - out0), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair valid.
REQ-005 SHALL have port: in_ready  output  1  divider idle, accepts operands.
REQ-006 SHALL have port: dividend  input  WIDTH  numerator.
REQ-007 SHALL have port: divisor  input  WIDTH  denominator.
REQ-008 SHALL have port: out_valid  output  1  quotient/remainder valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: quotient  output  WIDTH  result quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  result remainder.
REQ-012 SHALL have port: div_by_zero  output  1  flag, valid while out_valid.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, BUSY, FIX, DONE.
REQ-014 SHALL drive in_ready high only in IDLE and out_valid high only in DONE.
REQ-015 SHALL accept operands on a rising edge with in_valid and in_ready both high, registering dividend and divisor.
REQ-016 SHALL, on accept with a nonzero divisor, enter BUSY and run WIDTH restoring iterations, one quotient bit per cycle, MSB first.
REQ-017 SHALL form each partial remainder with a WIDTH+1-bit subtraction; the bit is 1 and the difference is kept when there is no borrow, else the bit is 0 and the remainder is restored.
REQ-018 SHALL move from BUSY to FIX after exactly WIDTH iterations, counted by a clog2(WIDTH+1)-bit counter, and from FIX to DONE one cycle later.
REQ-019 SHALL raise out_valid exactly WIDTH+2 rising edges after the accepting edge.
REQ-020 SHALL, on accept with divisor == 0, go straight to FIX and set quotient to all ones, remainder to the dividend and div_by_zero to 1, so out_valid rises 2 edges after accept.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable while out_valid is high and out_ready is low.
REQ-022 SHALL return to IDLE on the edge where out_valid and out_ready are both high; in_ready SHALL rise the following cycle, with no same-cycle accept in DONE.
REQ-023 SHALL ignore in_valid, dividend and divisor changes while not in IDLE.

Reset
REQ-024 SHALL on rst set the state to IDLE, in_ready to 1, out_valid to 0, quotient, remainder and div_by_zero to 0, and the iteration counter to 0.
REQ-025 SHALL, if rst is asserted mid-operation (BUSY, FIX or DONE), abandon the operation without ever asserting out_valid for it.
REQ-026 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-027 SHALL support macro SEQ_DIVIDER_SIGNED_EN; when defined, it adds input port in_signed (1 bit, sampled at accept) for two's-complement division.
REQ-028 SHALL, with SEQ_DIVIDER_SIGNED_EN defined and in_signed high, take operand magnitudes at accept and apply signs in FIX: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
REQ-029 SHALL, in signed mode, return quotient = most-negative value and remainder = 0 for most-negative / -1, and for divide-by-zero return quotient = all ones and remainder = the original dividend.
REQ-030 SHALL, without SEQ_DIVIDER_SIGNED_EN, omit in_signed, perform only unsigned division, and use FIX only as a pass-through cycle so that latency is identical in both builds.

Structure
REQ-031 SHALL place the FSM state enumeration, the default WIDTH constant and the counter-width function in shared package div_pkg.
REQ-032 SHALL instantiate one sub-module, cla_subtractor: a WIDTH+1-bit carry-lookahead subtractor that outputs the difference and borrow, is purely combinational, and is reused by the iteration datapath.

Verification
REQ-033 SHALL be verified with WIDTH=8, unsigned: 100/7 -> quotient 14, remainder 2, div_by_zero 0, out_valid 10 edges after accept.
REQ-034 SHALL be verified with WIDTH=8: 55/0 -> quotient 0xFF, remainder 55, div_by_zero 1, out_valid 2 edges after accept.
REQ-035 SHALL be verified with out_ready held low 5 cycles after 200/3: outputs hold 66/2 throughout, and in_ready rises the cycle after out_ready is asserted.
REQ-036 SHALL be verified by asserting rst during the 4th BUSY cycle: out_valid never asserts, in_ready is 1 the next cycle, and a following 9/4 returns 2/1.
REQ-037 SHALL be verified with SEQ_DIVIDER_SIGNED_EN, WIDTH=8: -7/2 -> -3 rem -1; 7/-2 -> -3 rem 1; -128/-1 -> -128 rem 0.
REQ-038 SHALL be verified with back-to-back operations, in_valid held high: each accept occurs only in IDLE, and 16 random pairs match a reference model.
